// File: rtl/urd_rx_fd_job_queue.sv
// FWFT job queue between the rx frame-decode controller and the processing stage.
// Optional per-type push statistics are enabled by URD_RX_FD_JOB_QUEUE_STATS_EN.
module urd_rx_fd_job_queue #(
    parameter int DEPTH        = 8,
    parameter int JOB_W        = 32,
    parameter int ERR_ID_W     = 8,
    parameter int EARLY_MARGIN = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_job,
    input  logic                       wr_err_job,
    input  logic [JOB_W-1:0]           wr_job_data,
    input  logic [ERR_ID_W-1:0]        wr_err_id,
    input  logic                       flush,
    output logic                       slot_available,
    output logic                       slot_available_early,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [JOB_W-1:0]           rd_job_data,
    output logic                       rd_is_error,
    output logic [ERR_ID_W-1:0]        rd_err_id,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic [15:0]                stat_job_cnt,
    output logic [15:0]                stat_err_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_EARLY = LW'(DEPTH - EARLY_MARGIN);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    logic [JOB_W-1:0]    mem_data [DEPTH];
    logic                mem_err  [DEPTH];
    logic [ERR_ID_W-1:0] mem_id   [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          push;
    logic          pop;
    logic          full;
    logic          accept;

    assign push   = wr_job | wr_err_job;
    assign full   = (level_q == LVL_FULL);
    assign pop    = rd_valid & rd_ready;
    // At full a push is only taken when the head leaves in the same cycle.
    assign accept = push & (~full | pop);

    assign rd_valid             = (level_q != '0);
    assign level                = level_q;
    assign slot_available       = (level_q < LVL_FULL);
    assign slot_available_early = (level_q < LVL_EARLY);

    // Head is masked while empty so the outputs read zero out of reset.
    assign rd_job_data = rd_valid ? mem_data[rd_ptr] : '0;
    assign rd_is_error = rd_valid ? mem_err[rd_ptr]  : 1'b0;
    assign rd_err_id   = rd_valid ? mem_id[rd_ptr]   : '0;

    always_ff @(posedge clk) begin
        if (!rst && !flush && accept) begin
            mem_data[wr_ptr] <= wr_job_data;
            mem_err[wr_ptr]  <= wr_err_job;
            mem_id[wr_ptr]   <= wr_err_job ? wr_err_id : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
            case ({accept, pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

`ifdef URD_RX_FD_JOB_QUEUE_STATS_EN
    logic [15:0] job_cnt;
    logic [15:0] err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            job_cnt <= '0;
            err_cnt <= '0;
        end else if (!flush && accept) begin
            if (!wr_err_job && job_cnt != 16'hFFFF) job_cnt <= job_cnt + 16'd1;
            if (wr_err_job  && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

    assign stat_job_cnt = job_cnt;
    assign stat_err_cnt = err_cnt;
`else
    assign stat_job_cnt = '0;
    assign stat_err_cnt = '0;
`endif

endmodule
